// File: rtl/prefetch_fetch_stage_pkg.sv
// Shared types and constants for the prefetching instruction-fetch front end.
package prefetch_fetch_stage_pkg;

  // Default core widths used when the fetch stage is instantiated without overrides.
  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  // Every fetch moves the address forward by one 32-bit instruction word.
  localparam int FETCH_INSTR_BYTES = 4;

  // IDLE : no imem request outstanding
  // BUSY : request outstanding; its response is pushed into the FIFO
  // DRAIN: request outstanding; its response is thrown away (redirected)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Clears the byte-offset bits so an address points at a whole instruction word.
  function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(input logic [RISCV_ADDR_WIDTH-1:0] addr);
    return addr & ~(RISCV_ADDR_WIDTH'(FETCH_INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/prefetch_fetch_stage_fetch_fifo.sv
// Show-ahead FIFO holding prefetched {instruction, address} entries.
// DEPTH may be any integer >= 1; pointers wrap explicitly at DEPTH-1.
// A flush empties the FIFO and takes priority over a push in the same cycle.
module prefetch_fetch_stage_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Advance a pointer, wrapping at the last entry (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Head is presented combinationally; an empty FIFO shows zero rather than stale data.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: written on push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/prefetch_fetch_stage.sv
// Instruction-fetch front end: issues sequential word fetches on imem, buffers
// the responses in a prefetch FIFO and hands them to the decoder. A redirect
// flushes the FIFO and turns any outstanding request into a discarded one.
module prefetch_fetch_stage
  import prefetch_fetch_stage_pkg::*;
#(
  parameter int                    DEPTH      = 2,
  parameter int                    ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter int                    WORD_WIDTH = RISCV_WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  target_valid_i,
  input  logic [ADDR_WIDTH-1:0] target_addr_i,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  imem_valid_o,
  input  logic                  imem_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [WORD_WIDTH-1:0] imem_wdata_o,
  output logic [3:0]            imem_we_o,
  input  logic [WORD_WIDTH-1:0] imem_rdata_i
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = WORD_WIDTH + ADDR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;

  logic [ADDR_WIDTH-1:0] target_aligned;
  logic [ADDR_WIDTH-1:0] fetch_addr_inc;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        cnt_n;
  logic                  room;

  logic [ENTRY_W-1:0]    fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Byte-offset bits of the redirect address are ignored.
  assign target_aligned = target_addr_i & ~(ADDR_WIDTH'(FETCH_INSTR_BYTES - 1));
  assign fetch_addr_inc = fetch_addr_q + ADDR_WIDTH'(FETCH_INSTR_BYTES);

  // Only a BUSY response that is not being redirected lands in the FIFO.
  assign pop  = instr_valid_o && instr_ready_i;
  assign push = (state_q == BUSY) && imem_ready_i && !target_valid_i && (!fifo_full || pop);

  // Occupancy after this cycle's push/pop (zero when flushing). A new request
  // may only start when it will have a guaranteed slot for its response.
  assign cnt_n = target_valid_i ? '0
               : ({1'b0, fifo_count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop));
  assign room  = (cnt_n < (CNT_W + 1)'(DEPTH));

  prefetch_fetch_stage_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (target_valid_i),
    .data_i  ({imem_rdata_i, imem_addr_q}),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign instr_o       = fifo_head[ENTRY_W-1:ADDR_WIDTH];
  assign instr_addr_o  = fifo_head[ADDR_WIDTH-1:0];
  assign instr_valid_o = !fifo_empty;

  // imem_valid_o comes straight from the state register, so it is glitch-free.
  assign imem_valid_o = (state_q != IDLE);
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = '0;
  assign imem_we_o    = 4'b0000;

  // Next state, next fetch address and next bus address; redirect always wins.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    imem_addr_d  = imem_addr_q;

    unique case (state_q)
      IDLE: begin
        if (target_valid_i) begin
          fetch_addr_d = target_aligned;
          if (req_i) begin
            state_d     = BUSY;
            imem_addr_d = target_aligned;
          end
        end else if (req_i && room) begin
          state_d     = BUSY;
          imem_addr_d = fetch_addr_q;
        end
      end

      BUSY: begin
        if (imem_ready_i) begin
          if (target_valid_i) begin
            // Response discarded; restart immediately at the target.
            fetch_addr_d = target_aligned;
            if (req_i) begin
              imem_addr_d = target_aligned;
            end else begin
              state_d = IDLE;
            end
          end else begin
            // Response pushed; continue back-to-back while there is room.
            fetch_addr_d = fetch_addr_inc;
            if (req_i && room) begin
              imem_addr_d = fetch_addr_inc;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (target_valid_i) begin
          // Bus address must stay put until the stalled request completes.
          state_d      = DRAIN;
          fetch_addr_d = target_aligned;
        end
      end

      DRAIN: begin
        if (target_valid_i) begin
          fetch_addr_d = target_aligned;
        end
        if (imem_ready_i) begin
          // The discarded response retires; a same-cycle redirect is followed
          // directly since nothing is outstanding any more.
          if (req_i) begin
            state_d     = BUSY;
            imem_addr_d = target_valid_i ? target_aligned : fetch_addr_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, fetch-address and bus-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_ADDR;
      imem_addr_q  <= RESET_ADDR;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

endmodule

// File: tb/tb_prefetch_fetch_stage.sv
// Directed testbench for prefetch_fetch_stage (DEPTH=2), plus a second instance
// with RESET_ADDR near the top of the address space for the wrap case.
module tb_prefetch_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        tgt_v = 1'b0;
  logic [31:0] tgt_a = '0;
  logic        instr_ready = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready;

  logic [31:0] instr, instr_addr, imem_addr, imem_wdata, imem_rdata;
  logic        instr_valid, imem_valid;
  logic [3:0]  imem_we;

  logic [31:0] instr_w, instr_addr_w, imem_addr_w, imem_wdata_w, imem_rdata_w;
  logic        instr_valid_w, imem_valid_w;
  logic [3:0]  imem_we_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from its address so data can be checked.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_ready   = !stall;
  assign imem_rdata   = mdata(imem_addr);
  assign imem_rdata_w = mdata(imem_addr_w);

  prefetch_fetch_stage #(
    .DEPTH(2), .ADDR_WIDTH(32), .WORD_WIDTH(32), .RESET_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .target_valid_i(tgt_v), .target_addr_i(tgt_a),
    .instr_o(instr), .instr_addr_o(instr_addr), .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready), .imem_valid_o(imem_valid), .imem_ready_i(imem_ready),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .imem_we_o(imem_we),
    .imem_rdata_i(imem_rdata)
  );

  prefetch_fetch_stage #(
    .DEPTH(2), .ADDR_WIDTH(32), .WORD_WIDTH(32), .RESET_ADDR(32'hFFFF_FFF8)
  ) dut_w (
    .clk(clk), .rst(rst), .req_i(req), .target_valid_i(tgt_v), .target_addr_i(tgt_a),
    .instr_o(instr_w), .instr_addr_o(instr_addr_w), .instr_valid_o(instr_valid_w),
    .instr_ready_i(instr_ready), .imem_valid_o(imem_valid_w), .imem_ready_i(imem_ready),
    .imem_addr_o(imem_addr_w), .imem_wdata_o(imem_wdata_w), .imem_we_o(imem_we_w),
    .imem_rdata_i(imem_rdata_w)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges with all inputs idle, release just after an edge.
  task automatic do_reset();
    rst = 1'b1; req = 1'b0; tgt_v = 1'b0; tgt_a = '0; instr_ready = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    $display("reset asserted t=%0t", $time);
    checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL reset_imem_valid got=%0b exp=0", imem_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=00000000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
    checks++; if (instr_addr !== 32'h0) begin failures++; $display("FAIL reset_instr_addr got=%h exp=00000000", instr_addr); end
    checks++; if (imem_addr_w !== 32'hFFFF_FFF8) begin failures++; $display("FAIL reset_imem_addr_w got=%h exp=fffffff8", imem_addr_w); end
    checks++; if ({imem_we, imem_we_w} !== 8'h00) begin failures++; $display("FAIL reset_we got=%h exp=00", {imem_we, imem_we_w}); end
    checks++; if ((imem_wdata | imem_wdata_w) !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=00000000", imem_wdata | imem_wdata_w); end
    do_reset();
    // With req low nothing may start.
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%0b exp=0", imem_valid); end
    end
    req = 1'b1;
    step();
    $display("first request addr=%h valid=%0b", imem_addr, imem_valid);
    checks++; if (imem_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%0b exp=1", imem_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_req_addr got=%h exp=00000000", imem_addr); end
  endtask

  task automatic test_streaming();
    logic [31:0] a;
    do_reset();
    req = 1'b1; instr_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL stream_addr0 got=%h exp=00000000", imem_addr); end
    for (int k = 1; k <= 6; k++) begin
      step();
      a = 32'(4 * (k - 1));
      $display("stream fetch=%h deliver=%h data=%h", imem_addr, instr_addr, instr);
      checks++; if (imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL stream_imem_addr got=%h exp=%h", imem_addr, 32'(4 * k)); end
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_instr_valid got=%0b exp=1", instr_valid); end
      checks++; if (instr_addr !== a) begin failures++; $display("FAIL stream_instr_addr got=%h exp=%h", instr_addr, a); end
      checks++; if (instr !== mdata(a)) begin failures++; $display("FAIL stream_instr got=%h exp=%h", instr, mdata(a)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 1'b1; instr_ready = 1'b0;
    step();
    step();
    checks++; if (imem_addr !== 32'h4 || imem_valid !== 1'b1) begin failures++; $display("FAIL bp_second_fetch got=%h/%0b exp=00000004/1", imem_addr, imem_valid); end
    step();
    for (int i = 0; i < 3; i++) begin
      $display("bp full imem_valid=%0b head=%h", imem_valid, instr_addr);
      checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL bp_full_no_req got=%0b exp=0", imem_valid); end
      checks++; if (instr_addr !== 32'h0 || instr_valid !== 1'b1) begin failures++; $display("FAIL bp_head got=%h/%0b exp=00000000/1", instr_addr, instr_valid); end
      if (i < 2) step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    $display("bp after pop imem_valid=%0b addr=%h head=%h", imem_valid, imem_addr, instr_addr);
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_refetch got=%h/%0b exp=00000008/1", imem_addr, imem_valid); end
    checks++; if (instr_addr !== 32'h4) begin failures++; $display("FAIL bp_head_after_pop got=%h exp=00000004", instr_addr); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_valid !== 1'b0) begin failures++; $display("FAIL bp_single_refetch got=%0b exp=0", imem_valid); end
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    req = 1'b1; instr_ready = 1'b1;
    repeat (5) step();
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL rs_pre_addr got=%h exp=00000010", imem_addr); end
    stall = 1'b1; tgt_v = 1'b1; tgt_a = 32'h203;
    step();
    tgt_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      $display("rs drain imem_addr=%h instr_valid=%0b", imem_addr, instr_valid);
      checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL rs_hold_addr got=%h/%0b exp=00000010/1", imem_addr, imem_valid); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rs_flushed got=%0b exp=0", instr_valid); end
      if (i == 0) step();
    end
    stall = 1'b0;
    step();
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rs_target_fetch got=%h/%0b exp=00000200/1", imem_addr, imem_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rs_discard got=%0b exp=0", instr_valid); end
    step();
    $display("rs delivered addr=%h data=%h", instr_addr, instr);
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h200) begin failures++; $display("FAIL rs_first_deliver got=%h/%0b exp=00000200/1", instr_addr, instr_valid); end
    checks++; if (instr !== mdata(32'h200)) begin failures++; $display("FAIL rs_first_data got=%h exp=%h", instr, mdata(32'h200)); end
  endtask

  task automatic test_double_redirect();
    do_reset();
    req = 1'b1; instr_ready = 1'b1;
    repeat (5) step();
    stall = 1'b1; tgt_v = 1'b1; tgt_a = 32'h100;
    step();
    tgt_a = 32'h300;
    step();
    tgt_v = 1'b0;
    checks++; if (imem_addr !== 32'h10 || instr_valid !== 1'b0) begin failures++; $display("FAIL dr_hold got=%h/%0b exp=00000010/0", imem_addr, instr_valid); end
    step();
    stall = 1'b0;
    step();
    $display("dr refetch addr=%h", imem_addr);
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL dr_fetch got=%h/%0b exp=00000300/1", imem_addr, imem_valid); end
    step();
    $display("dr delivered addr=%h", instr_addr);
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 32'h300) begin failures++; $display("FAIL dr_deliver got=%h/%0b exp=00000300/1", instr_addr, instr_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [4];
    exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    req = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      $display("wrap fetch=%h deliver=%h", imem_addr_w, instr_addr_w);
      checks++; if (imem_valid_w !== 1'b1 || imem_addr_w !== exp_w[k]) begin failures++; $display("FAIL wrap_fetch got=%h exp=%h", imem_addr_w, exp_w[k]); end
      if (k >= 1) begin
        checks++; if (instr_valid_w !== 1'b1 || instr_addr_w !== exp_w[k-1] || instr_w !== mdata(exp_w[k-1])) begin
          failures++; $display("FAIL wrap_deliver got=%h data=%h exp=%h", instr_addr_w, instr_w, exp_w[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 1'b1; instr_ready = 1'b0;
    repeat (3) step();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL rm_precond got=%0b exp=1", instr_valid); end
    #3 rst = 1'b1;
    #1;
    $display("mid-burst reset imem_valid=%0b instr_valid=%0b", imem_valid, instr_valid);
    checks++; if (imem_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rm_async got=%0b/%0b exp=0/0", imem_valid, instr_valid); end
    checks++; if (instr_addr !== 32'h0 || instr !== 32'h0) begin failures++; $display("FAIL rm_outputs got=%h/%h exp=0/0", instr_addr, instr); end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    $display("restart addr=%h", imem_addr);
    checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rm_restart got=%h/%0b exp=00000000/1", imem_addr, imem_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rm_empty got=%0b exp=0", instr_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_stall();
    test_double_redirect();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch_fetch_stage.md
Name: prefetch_fetch_stage

Overview:
Parametrised instruction-fetch front end for the RISC-V core, replacing the single-word fetch path.
- Issues sequential word fetches on the imem valid/ready interface.
- Buffers up to DEPTH fetched words in a prefetch FIFO.
- Hands them to the decoder over a valid/ready handshake.
- On a redirect, flushes the FIFO and any in-flight response.

Parameters:
DEPTH, 2, prefetch FIFO entries (>=1, any integer, need not be power of two)
ADDR_WIDTH, `RISCV_ADDR_WIDTH (32), fetch address width
WORD_WIDTH, `RISCV_WORD_WIDTH (32), instruction word width
RESET_ADDR, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_i  in  1  fetch enable; when low, no new imem request starts (an in-flight request still completes)
target_valid_i  in  1  redirect strobe, single-cycle
target_addr_i  in  ADDR_WIDTH  redirect address; bits [1:0] ignored (treated as 0)
instr_o  out  WORD_WIDTH  FIFO head instruction word
instr_addr_o  out  ADDR_WIDTH  address of instr_o
instr_valid_o  out  1  FIFO non-empty
instr_ready_i  in  1  decoder accepts head; pop occurs when instr_valid_o && instr_ready_i
imem_valid_o  out  1  request valid, registered
imem_ready_i  in  1  request done; imem_rdata_i is valid in this cycle
imem_addr_o  out  ADDR_WIDTH  word-aligned fetch address
imem_wdata_o  out  WORD_WIDTH  tied to 0
imem_we_o  out  4  tied to 4'b0000
imem_rdata_i  in  WORD_WIDTH  fetched word

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE, imem_valid_o=0, imem_addr_o=RESET_ADDR.
  - fetch_addr=RESET_ADDR, FIFO count=0, instr_valid_o=0.
  - instr_o=0, instr_addr_o=0.
  - Any in-flight request is abandoned.
- States:
  - IDLE: no request outstanding.
  - BUSY: imem_valid_o=1, fetching fetch_addr.
  - DRAIN: imem_valid_o=1, request outstanding, response will be discarded.
- Bus rule: while imem_valid_o=1, imem_addr_o is held stable until a cycle with imem_ready_i=1. At most one request is outstanding.
- Invariant: count + (state==BUSY) <= DEPTH at all times. An accepted response therefore always has a FIFO slot; overflow is impossible.
- Let cnt_n = count after this cycle's push/pop.
- IDLE -> BUSY when req_i && !target_valid_i && cnt_n < DEPTH. imem_valid_o rises on the next edge with imem_addr_o=fetch_addr.
- BUSY with imem_ready_i=1:
  - push {imem_rdata_i, imem_addr_o}; fetch_addr += 4, wrapping modulo 2^ADDR_WIDTH.
  - Stay BUSY (back-to-back, next address) if req_i && cnt_n < DEPTH; otherwise go to IDLE.
  - Zero-wait memory with a permanently ready consumer sustains 1 word/cycle.
- Latency: a word pushed on edge N shows instr_valid_o=1 after edge N. After reset release, the first imem_valid_o rises on the first clk edge where req_i=1.
- Redirect (target_valid_i=1) has priority over everything:
  - FIFO is flushed; instr_valid_o=0 after the edge. A pop in the same cycle is legal but irrelevant.
  - fetch_addr <= {target_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - From IDLE: go to BUSY at the target if req_i.
  - From BUSY with imem_ready_i=1: the response is discarded (no push); go to BUSY at the target if req_i, else IDLE.
  - From BUSY with imem_ready_i=0: go to DRAIN; imem_addr_o stays on the old address.
  - DRAIN with imem_ready_i=1: data discarded; go to BUSY at fetch_addr if req_i, else IDLE.
  - Redirect during DRAIN: fetch_addr is updated to the newest target; stay in DRAIN.
- Full FIFO with no pop: no new request is issued. Full FIFO with a pop and req_i: a request may issue next cycle.
- Simultaneous push and pop: count is unchanged; pointers wrap at DEPTH-1 -> 0.
- req_i dropped in BUSY: the in-flight request completes and is pushed, then go to IDLE.

Decomposition:
- riscv_defines.sv gains the state typedef fetch_state_e {IDLE, BUSY, DRAIN} and FETCH_INSTR_BYTES = 4.
- One sub-module: fetch_fifo.
  - Synchronous, show-ahead FIFO parameterised by DEPTH and entry width (WORD_WIDTH+ADDR_WIDTH).
  - Has push, pop, flush, count, empty and full.
  - Flush wins over push in the same cycle.
- The FSM and address counter live in prefetch_fetch_stage.

Test Plan:
1. Streaming: zero-wait memory, rst released, req_i=1, instr_ready_i=1 -> imem_addr_o 0x0,0x4,0x8... on consecutive cycles; instr_addr_o follows one cycle later; one word per cycle.
2. Backpressure: DEPTH=2, instr_ready_i=0 -> exactly 2 words buffered (0x0,0x4); imem_valid_o=0 thereafter. Raise instr_ready_i for one cycle -> one pop, then exactly one new fetch of 0x8.
3. Redirect while stalled: imem_ready_i=0 on fetch of 0x10, pulse target 0x203 -> imem_addr_o stays 0x10 until ready. Its data never appears; the next fetch is 0x200; the FIFO is empty in between.
4. Double redirect in DRAIN: targets 0x100 then 0x300 while waiting -> the first delivered instr_addr_o is 0x300.
5. Wrap: RESET_ADDR=0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. Reset mid-burst: assert rst asynchronously between edges with 2 words buffered -> imem_valid_o=0 and instr_valid_o=0 immediately; after release, fetch restarts at RESET_ADDR.
